// File: rtl/reg_scoreboard.sv
// reg_scoreboard
//   Physical integer register file with a per-register pending-write
//   scoreboard. Each register carries a busy bit and a branch-context tag.
//   N_READ issue ports fetch operands and reserve their destination
//   register. They stall on RAW and WAW hazards, take same-cycle write-back
//   data by forwarding, and are squashed when their context is flushed.
//   N_WRITE write-back ports update the file and clear busy.
//
// Ports
//   clk, rstn                          clock, async active-low reset
//   r_order / r_accepted / r_done      per-port issue handshake
//   r_pa_rs1/rs2/rd, r_use_rd          operand and destination addresses
//   r_context                          speculation context of the instruction
//   r_d_rs1/rs2, r_branch_hazard       operand data and squash flag (valid with r_done)
//   w_order, w_pa_rd, w_d_rd           write-back ports
//   lr_pa / lr_d / lr_undecided        side-band lookup
//   branch_hazard, hazard_context      mispredict flush
//   safe_context                       contexts resolved as correct
module reg_scoreboard #(
  parameter int N_READ        = 2,
  parameter int N_WRITE       = 2,
  parameter int LEN_PREG_ADDR = 5,
  parameter int LEN_WORD      = 32,
  parameter int LEN_CONTEXT   = 2
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic [N_READ-1:0]                 r_order,
  output logic [N_READ-1:0]                 r_accepted,
  output logic [N_READ-1:0]                 r_done,
  input  logic [N_READ*LEN_PREG_ADDR-1:0]   r_pa_rs1,
  input  logic [N_READ*LEN_PREG_ADDR-1:0]   r_pa_rs2,
  input  logic [N_READ*LEN_PREG_ADDR-1:0]   r_pa_rd,
  input  logic [N_READ-1:0]                 r_use_rd,
  input  logic [N_READ*LEN_CONTEXT-1:0]     r_context,
  output logic [N_READ*LEN_WORD-1:0]        r_d_rs1,
  output logic [N_READ*LEN_WORD-1:0]        r_d_rs2,
  output logic [N_READ-1:0]                 r_branch_hazard,
  input  logic [N_WRITE-1:0]                w_order,
  input  logic [N_WRITE*LEN_PREG_ADDR-1:0]  w_pa_rd,
  input  logic [N_WRITE*LEN_WORD-1:0]       w_d_rd,
  input  logic [LEN_PREG_ADDR-1:0]          lr_pa,
  output logic [LEN_WORD-1:0]               lr_d,
  output logic                              lr_undecided,
  input  logic                              branch_hazard,
  input  logic [LEN_CONTEXT-1:0]            hazard_context,
  input  logic [LEN_CONTEXT-1:0]            safe_context
);

  localparam int NREG = 2**LEN_PREG_ADDR;

  typedef logic [LEN_PREG_ADDR-1:0] addr_t;
  typedef logic [LEN_WORD-1:0]      word_t;
  typedef logic [LEN_CONTEXT-1:0]   ctx_t;

  // register file and scoreboard
  word_t             rf_q   [NREG];
  word_t             rf_d   [NREG];
  logic [NREG-1:0]   busy_q, busy_d;
  ctx_t              rctx_q [NREG];
  ctx_t              rctx_d [NREG];

  // per-port latched instruction
  logic [N_READ-1:0] pbusy_q, pbusy_d;
  addr_t             prs1_q [N_READ];
  addr_t             prs1_d [N_READ];
  addr_t             prs2_q [N_READ];
  addr_t             prs2_d [N_READ];
  addr_t             prd_q  [N_READ];
  addr_t             prd_d  [N_READ];
  logic [N_READ-1:0] puse_q, puse_d;
  ctx_t              pctx_q [N_READ];
  ctx_t              pctx_d [N_READ];

  // effective (latched or live) per-port view
  addr_t             rs1_e  [N_READ];
  addr_t             rs2_e  [N_READ];
  addr_t             rd_e   [N_READ];
  logic [N_READ-1:0] use_e;
  ctx_t              ctx_e  [N_READ];
  logic [N_READ-1:0] acc, done, squash, resv;

  function automatic logic wr_hit(input addr_t a,
                                  input logic [N_WRITE-1:0] ord,
                                  input logic [N_WRITE*LEN_PREG_ADDR-1:0] pa);
    wr_hit = 1'b0;
    for (int k = 0; k < N_WRITE; k++)
      if (ord[k] && (pa[k*LEN_PREG_ADDR +: LEN_PREG_ADDR] == a)) wr_hit = 1'b1;
  endfunction

  // Later write ports override earlier ones, matching the write-back priority.
  function automatic word_t fwd(input addr_t a, input word_t rfv,
                                input logic [N_WRITE-1:0] ord,
                                input logic [N_WRITE*LEN_PREG_ADDR-1:0] pa,
                                input logic [N_WRITE*LEN_WORD-1:0] d);
    fwd = rfv;
    for (int k = 0; k < N_WRITE; k++)
      if (ord[k] && (pa[k*LEN_PREG_ADDR +: LEN_PREG_ADDR] == a))
        fwd = d[k*LEN_WORD +: LEN_WORD];
    if (a == '0) fwd = '0;
  endfunction

  // Port evaluation in index order: a lower port reserving an rd blocks a
  // higher port that wants the same rd in the same cycle (WAW).
  always_comb begin
    logic [N_READ-1:0] resv_l;
    logic              rs1_rdy, rs2_rdy, rd_rdy;
    resv_l = '0;
    acc    = '0;
    done   = '0;
    squash = '0;
    use_e  = '0;
    for (int i = 0; i < N_READ; i++) begin
      acc[i]   = r_order[i] & ~pbusy_q[i];
      rs1_e[i] = pbusy_q[i] ? prs1_q[i] : r_pa_rs1[i*LEN_PREG_ADDR +: LEN_PREG_ADDR];
      rs2_e[i] = pbusy_q[i] ? prs2_q[i] : r_pa_rs2[i*LEN_PREG_ADDR +: LEN_PREG_ADDR];
      rd_e[i]  = pbusy_q[i] ? prd_q[i]  : r_pa_rd[i*LEN_PREG_ADDR +: LEN_PREG_ADDR];
      use_e[i] = pbusy_q[i] ? puse_q[i] : r_use_rd[i];
      ctx_e[i] = pbusy_q[i] ? pctx_q[i] : r_context[i*LEN_CONTEXT +: LEN_CONTEXT];

      squash[i] = branch_hazard & (|(ctx_e[i] & hazard_context));
      rs1_rdy = (rs1_e[i] == '0) | ~busy_q[rs1_e[i]] | wr_hit(rs1_e[i], w_order, w_pa_rd);
      rs2_rdy = (rs2_e[i] == '0) | ~busy_q[rs2_e[i]] | wr_hit(rs2_e[i], w_order, w_pa_rd);
      rd_rdy  = ~use_e[i] | (rd_e[i] == '0) | ~busy_q[rd_e[i]] |
                wr_hit(rd_e[i], w_order, w_pa_rd);
      for (int j = 0; j < N_READ; j++)
        if (j < i && resv_l[j] && (rd_e[j] == rd_e[i])) rd_rdy = 1'b0;

      done[i]   = (pbusy_q[i] | acc[i]) & (squash[i] | (rs1_rdy & rs2_rdy & rd_rdy));
      resv_l[i] = done[i] & ~squash[i] & use_e[i] & (rd_e[i] != '0);
    end
    resv = resv_l;
  end

  // Outputs are forced low while reset is held.
  always_comb begin
    r_accepted      = '0;
    r_done          = '0;
    r_branch_hazard = '0;
    r_d_rs1         = '0;
    r_d_rs2         = '0;
    lr_d            = '0;
    lr_undecided    = 1'b0;
    if (rstn) begin
      r_accepted      = acc;
      r_done          = done;
      r_branch_hazard = done & squash;
      for (int i = 0; i < N_READ; i++) begin
        r_d_rs1[i*LEN_WORD +: LEN_WORD] = fwd(rs1_e[i], rf_q[rs1_e[i]], w_order, w_pa_rd, w_d_rd);
        r_d_rs2[i*LEN_WORD +: LEN_WORD] = fwd(rs2_e[i], rf_q[rs2_e[i]], w_order, w_pa_rd, w_d_rd);
      end
      lr_d         = fwd(lr_pa, rf_q[lr_pa], w_order, w_pa_rd, w_d_rd);
      lr_undecided = (lr_pa != '0) & busy_q[lr_pa] & ~wr_hit(lr_pa, w_order, w_pa_rd);
    end
  end

  // Next state. Order matters: write clear and flush first, then new
  // reservations override them, then safe resolution clears context bits last.
  always_comb begin
    addr_t wa;
    rf_d   = rf_q;
    busy_d = busy_q;
    rctx_d = rctx_q;
    for (int k = 0; k < N_WRITE; k++) begin
      wa = w_pa_rd[k*LEN_PREG_ADDR +: LEN_PREG_ADDR];
      if (w_order[k] && (wa != '0)) begin
        rf_d[wa]   = w_d_rd[k*LEN_WORD +: LEN_WORD];
        busy_d[wa] = 1'b0;
      end
    end
    if (branch_hazard) begin
      for (int p = 0; p < NREG; p++)
        if (|(rctx_q[p] & hazard_context)) begin
          busy_d[p] = 1'b0;
          rctx_d[p] = '0;
        end
    end
    for (int i = 0; i < N_READ; i++)
      if (resv[i]) begin
        busy_d[rd_e[i]] = 1'b1;
        rctx_d[rd_e[i]] = ctx_e[i];
      end
    for (int p = 0; p < NREG; p++) rctx_d[p] = rctx_d[p] & ~safe_context;

    for (int i = 0; i < N_READ; i++) begin
      if (done[i])     pbusy_d[i] = 1'b0;
      else if (acc[i]) pbusy_d[i] = 1'b1;
      else             pbusy_d[i] = pbusy_q[i];
      prs1_d[i] = rs1_e[i];
      prs2_d[i] = rs2_e[i];
      prd_d[i]  = rd_e[i];
      puse_d[i] = use_e[i];
      pctx_d[i] = ctx_e[i] & ~safe_context;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy_q  <= '0;
      pbusy_q <= '0;
      puse_q  <= '0;
      for (int p = 0; p < NREG; p++) begin
        rf_q[p]   <= '0;
        rctx_q[p] <= '0;
      end
      for (int i = 0; i < N_READ; i++) begin
        prs1_q[i] <= '0;
        prs2_q[i] <= '0;
        prd_q[i]  <= '0;
        pctx_q[i] <= '0;
      end
    end else begin
      busy_q  <= busy_d;
      pbusy_q <= pbusy_d;
      puse_q  <= puse_d;
      for (int p = 0; p < NREG; p++) begin
        rf_q[p]   <= rf_d[p];
        rctx_q[p] <= rctx_d[p];
      end
      for (int i = 0; i < N_READ; i++) begin
        prs1_q[i] <= prs1_d[i];
        prs2_q[i] <= prs2_d[i];
        prd_q[i]  <= prd_d[i];
        pctx_q[i] <= pctx_d[i];
      end
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
module tb_reg_scoreboard;
  localparam int NR = 2;
  localparam int NW = 2;
  localparam int A  = 5;
  localparam int W  = 32;
  localparam int C  = 2;

  logic            clk;
  logic            rstn;
  logic [NR-1:0]   r_order, r_accepted, r_done, r_use_rd, r_branch_hazard;
  logic [NR*A-1:0] r_pa_rs1, r_pa_rs2, r_pa_rd;
  logic [NR*C-1:0] r_context;
  logic [NR*W-1:0] r_d_rs1, r_d_rs2;
  logic [NW-1:0]   w_order;
  logic [NW*A-1:0] w_pa_rd;
  logic [NW*W-1:0] w_d_rd;
  logic [A-1:0]    lr_pa;
  logic [W-1:0]    lr_d;
  logic            lr_undecided;
  logic            branch_hazard;
  logic [C-1:0]    hazard_context, safe_context;

  int n_cmp = 0;
  int n_bad = 0;

  reg_scoreboard #(.N_READ(NR), .N_WRITE(NW), .LEN_PREG_ADDR(A), .LEN_WORD(W),
                   .LEN_CONTEXT(C)) dut (
    .clk(clk), .rstn(rstn),
    .r_order(r_order), .r_accepted(r_accepted), .r_done(r_done),
    .r_pa_rs1(r_pa_rs1), .r_pa_rs2(r_pa_rs2), .r_pa_rd(r_pa_rd),
    .r_use_rd(r_use_rd), .r_context(r_context),
    .r_d_rs1(r_d_rs1), .r_d_rs2(r_d_rs2), .r_branch_hazard(r_branch_hazard),
    .w_order(w_order), .w_pa_rd(w_pa_rd), .w_d_rd(w_d_rd),
    .lr_pa(lr_pa), .lr_d(lr_d), .lr_undecided(lr_undecided),
    .branch_hazard(branch_hazard), .hazard_context(hazard_context),
    .safe_context(safe_context)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_port(input int i, input logic ord, input logic [A-1:0] rs1,
                          input logic [A-1:0] rs2, input logic [A-1:0] rd,
                          input logic use_rd, input logic [C-1:0] ctx);
    r_order[i]         = ord;
    r_pa_rs1[i*A +: A] = rs1;
    r_pa_rs2[i*A +: A] = rs2;
    r_pa_rd[i*A +: A]  = rd;
    r_use_rd[i]        = use_rd;
    r_context[i*C +: C] = ctx;
  endtask

  task automatic set_wr(input int k, input logic ord, input logic [A-1:0] a,
                        input logic [W-1:0] d);
    w_order[k]       = ord;
    w_pa_rd[k*A +: A] = a;
    w_d_rd[k*W +: W]  = d;
  endtask

  task automatic clear_inputs();
    r_order = '0; r_pa_rs1 = '0; r_pa_rs2 = '0; r_pa_rd = '0;
    r_use_rd = '0; r_context = '0;
    w_order = '0; w_pa_rd = '0; w_d_rd = '0;
    lr_pa = '0; branch_hazard = 1'b0; hazard_context = '0; safe_context = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    rstn = 1'b0;
    clear_inputs();
    // reset: outputs held low even with live requests and a forwarding write
    set_port(0, 1'b1, 5'd3, 5'd4, 5'd5, 1'b1, 2'b00);
    set_port(1, 1'b1, 5'd6, 5'd0, 5'd0, 1'b0, 2'b00);
    set_wr(0, 1'b1, 5'd6, 32'h1234);
    lr_pa = 5'd6;
    #2;
    check("rst_accepted", r_accepted, 2'b00);
    check("rst_done", r_done, 2'b00);
    check("rst_lr_d", lr_d, 32'h0);
    check("rst_d_rs1_p1", r_d_rs1[W +: W], 32'h0);
    check("rst_lr_undecided", lr_undecided, 1'b0);

    step(); rstn = 1'b1; clear_inputs();

    // zero-stall issue on port 0
    step();
    set_port(0, 1'b1, 5'd3, 5'd4, 5'd5, 1'b1, 2'b00);
    sample();
    check("t1_accepted", r_accepted, 2'b01);
    check("t1_done", r_done, 2'b01);
    check("t1_bh", r_branch_hazard, 2'b00);
    check("t1_rs1", r_d_rs1[0 +: W], 32'h0);
    check("t1_rs2", r_d_rs2[0 +: W], 32'h0);
    step(); clear_inputs(); lr_pa = 5'd5;
    sample();
    check("t1_busy5", lr_undecided, 1'b1);

    // RAW stall on port 1, released by write-back with forwarding
    step(); clear_inputs();
    set_port(1, 1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 2'b00);
    sample();
    check("t2_accepted", r_accepted, 2'b10);
    check("t2_done_stall", r_done, 2'b00);
    step();
    set_port(1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00);  // live rs1 changed, latched 5 holds
    sample();
    check("t2_accepted_busy", r_accepted, 2'b00);
    check("t2_done_stall2", r_done, 2'b00);
    step(); clear_inputs();
    set_wr(0, 1'b1, 5'd5, 32'hDEADBEEF);
    lr_pa = 5'd5;
    sample();
    check("t2_done_fwd", r_done, 2'b10);
    check("t2_rs1_fwd", r_d_rs1[W +: W], 32'hDEADBEEF);
    check("t2_lr_und_wr", lr_undecided, 1'b0);
    check("t2_lr_fwd", lr_d, 32'hDEADBEEF);
    step(); clear_inputs(); lr_pa = 5'd5;
    sample();
    check("t2_lr_rf", lr_d, 32'hDEADBEEF);
    check("t2_busy5_clr", lr_undecided, 1'b0);
    check("t2_done_idle", r_done, 2'b00);

    // WAW: both ports reserve rd=7
    step(); clear_inputs();
    set_port(0, 1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 2'b00);
    set_port(1, 1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 2'b00);
    sample();
    check("t3_accepted", r_accepted, 2'b11);
    check("t3_done", r_done, 2'b01);
    step(); clear_inputs();
    sample();
    check("t3_p1_wait", r_done, 2'b00);
    step(); clear_inputs();
    set_wr(1, 1'b1, 5'd7, 32'h77);
    sample();
    check("t3_p1_done", r_done, 2'b10);
    step(); clear_inputs(); lr_pa = 5'd7;
    sample();
    check("t3_resv_wins", lr_undecided, 1'b1);
    check("t3_lr_d", lr_d, 32'h77);
    step(); clear_inputs(); set_wr(0, 1'b1, 5'd7, 32'h78);
    step(); clear_inputs(); lr_pa = 5'd7;
    sample();
    check("t3_busy7_clr", lr_undecided, 1'b0);
    check("t3_lr_d2", lr_d, 32'h78);

    // context squash
    step(); clear_inputs();
    set_port(0, 1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 2'b01);
    sample();
    check("t4_resv_done", r_done, 2'b01);
    step(); clear_inputs();
    set_port(1, 1'b1, 5'd9, 5'd0, 5'd0, 1'b0, 2'b01);
    sample();
    check("t4_stall", r_done, 2'b00);
    step(); clear_inputs();
    branch_hazard = 1'b1; hazard_context = 2'b01; lr_pa = 5'd9;
    sample();
    check("t4_squash_done", r_done, 2'b10);
    check("t4_squash_bh", r_branch_hazard, 2'b10);
    check("t4_busy9_pre", lr_undecided, 1'b1);
    step(); clear_inputs(); lr_pa = 5'd9;
    sample();
    check("t4_busy9_flushed", lr_undecided, 1'b0);

    // safe resolution shields a reservation from a later flush
    step(); clear_inputs();
    set_port(0, 1'b1, 5'd0, 5'd0, 5'd10, 1'b1, 2'b01);
    sample();
    check("t5_resv_done", r_done, 2'b01);
    step(); clear_inputs(); safe_context = 2'b01;
    step(); clear_inputs(); branch_hazard = 1'b1; hazard_context = 2'b01;
    step(); clear_inputs(); lr_pa = 5'd10;
    sample();
    check("t5_busy10_kept", lr_undecided, 1'b1);
    step(); clear_inputs(); set_wr(0, 1'b1, 5'd10, 32'hA5);
    step(); clear_inputs(); lr_pa = 5'd10;
    sample();
    check("t5_busy10_clr", lr_undecided, 1'b0);

    // dual write to reg 6 while port 0 reads it
    step(); clear_inputs();
    set_wr(0, 1'b1, 5'd6, 32'h11);
    set_wr(1, 1'b1, 5'd6, 32'h22);
    set_port(0, 1'b1, 5'd6, 5'd0, 5'd0, 1'b0, 2'b00);
    sample();
    check("t6_done", r_done, 2'b01);
    check("t6_rs1_hi", r_d_rs1[0 +: W], 32'h22);
    check("t6_rs2_zero", r_d_rs2[0 +: W], 32'h0);
    step(); clear_inputs(); lr_pa = 5'd6;
    sample();
    check("t6_rf", lr_d, 32'h22);

    // reset mid-stall
    step(); clear_inputs();
    set_port(0, 1'b1, 5'd0, 5'd0, 5'd12, 1'b1, 2'b00);
    step(); clear_inputs();
    set_port(1, 1'b1, 5'd12, 5'd6, 5'd0, 1'b0, 2'b00);
    sample();
    check("t7_stall", r_done, 2'b00);
    check("t7_acc", r_accepted, 2'b10);
    step();
    rstn = 1'b0;
    set_port(0, 1'b1, 5'd6, 5'd0, 5'd0, 1'b0, 2'b00);
    set_wr(0, 1'b1, 5'd12, 32'hCAFE);
    lr_pa = 5'd12;
    #1;
    check("t7_rst_acc", r_accepted, 2'b00);
    check("t7_rst_done", r_done, 2'b00);
    check("t7_rst_rs1", r_d_rs1, 64'h0);
    check("t7_rst_lrd", lr_d, 32'h0);
    check("t7_rst_und", lr_undecided, 1'b0);
    step(); rstn = 1'b1; clear_inputs(); lr_pa = 5'd12;
    sample();
    check("t7_post_busy", lr_undecided, 1'b0);
    check("t7_post_rf", lr_d, 32'h0);
    step(); clear_inputs();
    set_port(1, 1'b1, 5'd12, 5'd6, 5'd0, 1'b0, 2'b00);
    sample();
    check("t7_post_acc", r_accepted, 2'b10);
    check("t7_post_done", r_done, 2'b10);
    check("t7_post_rs2", r_d_rs2[W +: W], 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
Parametrised successor of the single-port register manager.
- Owns the physical integer register file and a per-register pending-write scoreboard with branch-context tags.
- Serves N_READ issue ports with order/accepted/done handshakes, RAW/WAW stall, same-cycle write forwarding and context-based squash.
- Sits between decode/dispatch and the execution units; write-back comes in on N_WRITE ports.

Parameters:
N_READ, 2, number of issue (operand-read) ports
N_WRITE, 2, number of write-back ports
LEN_PREG_ADDR, 5, physical register address width (2**LEN_PREG_ADDR registers, reg 0 hardwired 0)
LEN_WORD, 32, data width
LEN_CONTEXT, 2, one-hot-per-bit branch context width

Ports:
clk  in  1  clock
rstn  in  1  reset, asynchronous, active-low
r_order  in  N_READ  per-port issue request
r_accepted  out  N_READ  per-port accept pulse
r_done  out  N_READ  per-port completion pulse
r_pa_rs1  in  N_READ*LEN_PREG_ADDR  source 1 address, port i at slice i
r_pa_rs2  in  N_READ*LEN_PREG_ADDR  source 2 address
r_pa_rd  in  N_READ*LEN_PREG_ADDR  destination address
r_use_rd  in  N_READ  instruction writes rd
r_context  in  N_READ*LEN_CONTEXT  speculation context of the instruction
r_d_rs1  out  N_READ*LEN_WORD  source 1 data, valid when r_done
r_d_rs2  out  N_READ*LEN_WORD  source 2 data, valid when r_done
r_branch_hazard  out  N_READ  instruction squashed, valid when r_done
w_order  in  N_WRITE  write-back valid
w_pa_rd  in  N_WRITE*LEN_PREG_ADDR  write-back address
w_d_rd  in  N_WRITE*LEN_WORD  write-back data
lr_pa  in  LEN_PREG_ADDR  side-band lookup address
lr_d  out  LEN_WORD  side-band data, forwarded
lr_undecided  out  1  lookup register has a pending write
branch_hazard  in  1  mispredict flush strobe
hazard_context  in  LEN_CONTEXT  contexts being squashed
safe_context  in  LEN_CONTEXT  contexts resolved correct

Behaviour:
Reset (rstn low, async):
- All registers 0; busy[] 0; ctx[] 0; all port busy flags 0.
- Outputs: r_accepted, r_done, r_branch_hazard and lr_undecided are 0; data outputs are 0.

Per-port handshake (port i):
- r_accepted[i] = r_order[i] & ~pbusy[i], combinational.
- On accept, rs1/rs2/rd/use_rd/context are latched. While pbusy[i], latched values are used; on the accept cycle, the live inputs are used.
- pbusy[i] is set on accept and cleared on the cycle r_done[i] is high.
- Done may occur in the accept cycle (zero-stall latency 0 cycles).

Readiness:
- rs ready = (rs == 0) | ~busy[rs] | (some w_order[k] with w_pa_rd[k] == rs this cycle).
- rd ready = ~use_rd | (rd == 0) | ~busy[rd] | (written this cycle).
- rd ready additionally requires that no lower-index port reserves the same rd in this cycle.
- r_done[i] = pbusy_eff & (squash | (rs1 ready & rs2 ready & rd ready)).

Data:
- Read data = 0 for reg 0.
- Otherwise, forward from the highest-index matching write port this cycle, else the register file.

Squash:
- squash[i] = branch_hazard & |(ctx_i & hazard_context).
- On squash: r_done and r_branch_hazard are asserted, and no reservation is made.

Reservation:
- On non-squashed done with use_rd & rd != 0: busy[rd] <= 1 and ctx[rd] <= ctx_i.

Write-back:
- Register file is written at the clock edge, and busy[rd] is cleared.
- Two writes to the same register in one cycle: the highest index wins.
- Same-cycle write clear and new reservation on one register: the reservation wins (busy stays 1, ctx updated). Writes to reg 0 are ignored.

Flush:
- On branch_hazard, every register with |(ctx & hazard_context) has busy cleared and ctx cleared.
- Latched port contexts are not altered; squash is evaluated from them.

Safe resolution:
- Each cycle, ctx[p] <= ctx[p] & ~safe_context for all p and for all latched port contexts.
- When set and clear hit the same bit in one cycle, the clear takes priority.

Side-band lookup:
- lr_d uses the same forwarding rule as the read ports.
- lr_undecided = busy[lr_pa] & ~(written this cycle); lr_pa == 0 gives 0.

Test Plan:
- Reset then port0 order rs1=3, rs2=4, rd=5, use_rd=1 -> accepted and done in the same cycle, data 0/0, busy[5]=1 next cycle.
- Port0 reserves rd=5; next cycle port1 reads rs1=5 -> stalls; w_order writes 5 with 0xDEADBEEF -> port1 done that cycle with r_d_rs1=0xDEADBEEF, busy[5]=0.
- Port0 and port1 both reserve rd=7 in the same cycle -> port0 done, port1 waits until a write to 7; WAW enforced.
- Reservation rd=9 under context 2'b01, then branch_hazard with hazard_context=01 -> busy[9] cleared; a pending port with ctx 01 completes with r_branch_hazard=1.
- safe_context=01 one cycle before branch_hazard with hazard_context=01 -> reg not cleared; busy holds until write-back.
- Both write ports target reg 6 (0x11, 0x22) while port0 reads 6 -> r_d_rs1=0x22 and the register file holds 0x22; rstn asserted mid-stall -> all outputs 0 immediately.
